riscv_run_monitor: RTL and testbench

//  Parametrised run controller/monitor for the RISCVpipeline core. Generates the core's reset

---
 rtl/riscv_mon_pkg.sv | 27 ++
 rtl/mon_trace_fifo.sv | 47 ++++
 rtl/riscv_run_monitor.sv | 113 +++++++++++
 tb/tb_riscv_run_monitor.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mon_pkg.sv
// Shared definitions for the run monitor: FSM encodings, default halt word, trace entry layout.
// No logic here: constants, types and a saturating increment helper only.
// No flow control of its own; the users of these types apply it.
package riscv_mon_pkg;

   localparam logic [1:0] ST_HOLD    = 2'b00;
   localparam logic [1:0] ST_RUN     = 2'b01;
   localparam logic [1:0] ST_HALTED  = 2'b10;
   localparam logic [1:0] ST_TIMEOUT = 2'b11;

   localparam int          DEF_XLEN      = 32;
   localparam logic [31:0] DEF_HALT_INSN = 32'h0000_0073;

   typedef struct packed {
      logic [DEF_XLEN-1:0] pc;
      logic [DEF_XLEN-1:0] ins;
   } trace_entry_t;

   function automatic int trace_width(input int xlen);
      return 2 * xlen;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/mon_trace_fifo.sv
// First-word-fall-through trace FIFO; head entry is visible on pop_dat while non-empty.
// Latency: a push is visible at the head one cycle later; pop takes effect on the clock edge.
// Backpressure: push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
module mon_trace_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_dat,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             do_push;
   logic             do_pop;

   // The extra top bit tells a full FIFO apart from an empty one when the indices match.
   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign pop_dat = mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= push_dat;
   end

endmodule

// File: rtl/riscv_run_monitor.sv
// Run controller for the pipeline core: holds core_rst, then tracks pc/instruction until halt or timeout.
// Latency: all outputs registered; core_rst drops RST_HOLD cycles after rst releases.
// Backpressure: trace entries that find the FIFO full are dropped and flagged in sticky trace_ovf.
module riscv_run_monitor
   import riscv_mon_pkg::*;
#(
   parameter int              XLEN           = DEF_XLEN,
   parameter int              RST_HOLD       = 5,
   parameter int              TIMEOUT_CYCLES = 1024,
   parameter int              STALL_LIMIT    = 4,
   parameter int              TRACE_DEPTH    = 16,
   parameter logic [XLEN-1:0] HALT_INSN      = XLEN'(DEF_HALT_INSN)
) (
   input  logic            clk,
   input  logic            rst,
   output logic            core_rst,
   input  logic [XLEN-1:0] current_pc,
   input  logic [XLEN-1:0] instruction,
   input  logic            trace_rd,
   output logic            trace_valid,
   output logic [XLEN-1:0] trace_pc,
   output logic [XLEN-1:0] trace_ins,
   output logic            trace_ovf,
   output logic [31:0]     cycle_cnt,
   output logic [31:0]     retire_cnt,
   output logic [1:0]      state,
   output logic            done
);

   localparam int TW = trace_width(XLEN);

   logic [1:0]      st;
   logic [31:0]     hold_cnt;
   logic [31:0]     stall_cnt;
   logic [31:0]     stall_nxt;
   logic [XLEN-1:0] prev_pc;
   logic            first;
   logic            run;
   logic            pc_chg;
   logic            halt_hit;
   logic            tmo_hit;
   logic            push;
   logic            pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [TW-1:0]   head;

   assign run       = (st == ST_RUN);
   // The first RUN sample is always a retirement, even if the core starts at pc 0.
   assign pc_chg    = first || (current_pc != prev_pc);
   assign stall_nxt = pc_chg ? 32'd0 : stall_cnt + 32'd1;
   assign halt_hit  = (instruction == HALT_INSN) || (stall_nxt >= 32'(STALL_LIMIT - 1));
   assign tmo_hit   = (cycle_cnt == 32'(TIMEOUT_CYCLES - 1));
   assign push      = run && pc_chg;
   assign pop       = trace_rd && (st != ST_HOLD);

   assign state                 = st;
   assign done                  = (st == ST_HALTED) || (st == ST_TIMEOUT);
   assign trace_valid           = !fifo_empty;
   assign {trace_pc, trace_ins} = head;

   always_ff @(posedge clk) begin
      if (!rst) begin
         st         <= ST_HOLD;
         core_rst   <= 1'b1;
         hold_cnt   <= '0;
         stall_cnt  <= '0;
         prev_pc    <= '0;
         first      <= 1'b1;
         cycle_cnt  <= '0;
         retire_cnt <= '0;
         trace_ovf  <= 1'b0;
      end else begin
         if (push && fifo_full && !(pop && !fifo_empty)) trace_ovf <= 1'b1;
         case (st)
            ST_HOLD: begin
               hold_cnt <= hold_cnt + 32'd1;
               if (hold_cnt == 32'(RST_HOLD - 1)) begin
                  st       <= ST_RUN;
                  core_rst <= 1'b0;
                  first    <= 1'b1;
                  prev_pc  <= '0;
               end
            end
            ST_RUN: begin
               cycle_cnt <= sat_inc(cycle_cnt);
               if (pc_chg) retire_cnt <= sat_inc(retire_cnt);
               stall_cnt <= stall_nxt;
               prev_pc   <= current_pc;
               first     <= 1'b0;
               if (halt_hit)     st <= ST_HALTED;
               else if (tmo_hit) st <= ST_TIMEOUT;
            end
            default: ;
         endcase
      end
   end

   mon_trace_fifo #(
      .WIDTH (TW),
      .DEPTH (TRACE_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_dat ({current_pc, instruction}),
      .pop      (pop),
      .pop_dat  (head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

endmodule

// File: tb/tb_riscv_run_monitor.sv
// Bench for riscv_run_monitor: directed scenarios plus random traffic, checked every cycle against a queue model.
module tb_riscv_run_monitor;
   import riscv_mon_pkg::*;

   localparam int          RST_HOLD = 5;
   localparam int          TMO      = 16;
   localparam int          STALL    = 4;
   localparam int          DEPTH    = 8;
   localparam logic [31:0] HALT     = 32'h0000_0073;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        core_rst;
   logic [31:0] current_pc;
   logic [31:0] instruction;
   logic        trace_rd;
   logic        trace_valid;
   logic [31:0] trace_pc;
   logic [31:0] trace_ins;
   logic        trace_ovf;
   logic [31:0] cycle_cnt;
   logic [31:0] retire_cnt;
   logic [1:0]  state;
   logic        done;

   int checks   = 0;
   int failures = 0;

   riscv_run_monitor #(
      .XLEN(32), .RST_HOLD(RST_HOLD), .TIMEOUT_CYCLES(TMO),
      .STALL_LIMIT(STALL), .TRACE_DEPTH(DEPTH), .HALT_INSN(HALT)
   ) dut (
      .clk(clk), .rst(rst), .core_rst(core_rst),
      .current_pc(current_pc), .instruction(instruction),
      .trace_rd(trace_rd), .trace_valid(trace_valid),
      .trace_pc(trace_pc), .trace_ins(trace_ins), .trace_ovf(trace_ovf),
      .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt),
      .state(state), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: mode number, countdown, counters, and the trace as a plain queue.
   int           m_st;
   bit           m_core_rst;
   int           m_hold;
   longint       m_cyc;
   longint       m_ret;
   bit           m_ovf;
   bit           m_first;
   logic [31:0]  m_last;
   int           m_runlen;
   trace_entry_t m_q[$];
   bit           m_started = 0;

   always @(posedge clk) begin
      bit chg;
      m_started = 1;
      if (rst !== 1'b1) begin
         m_st = 0; m_core_rst = 1; m_hold = RST_HOLD; m_q.delete();
         m_ovf = 0; m_cyc = 0; m_ret = 0; m_first = 1; m_runlen = 0; m_last = 0;
      end else begin
         if (m_st != 0 && trace_rd && m_q.size() > 0) void'(m_q.pop_front());
         if (m_st == 0) begin
            m_hold--;
            if (m_hold == 0) begin m_st = 1; m_core_rst = 0; m_first = 1; end
         end else if (m_st == 1) begin
            chg = m_first || (current_pc != m_last);
            m_cyc++;
            if (chg) begin
               m_ret++;
               m_runlen = 1;
               if (m_q.size() < DEPTH) m_q.push_back('{pc: current_pc, ins: instruction});
               else m_ovf = 1;
            end else begin
               m_runlen++;
            end
            m_last  = current_pc;
            m_first = 0;
            if (instruction == HALT || m_runlen >= STALL) m_st = 2;
            else if (m_cyc == TMO) m_st = 3;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (m_started) begin
         chk("state", state, m_st);
         chk("core_rst", core_rst, m_core_rst);
         chk("done", done, m_st >= 2);
         chk("cycle_cnt", cycle_cnt, m_cyc);
         chk("retire_cnt", retire_cnt, m_ret);
         chk("trace_ovf", trace_ovf, m_ovf);
         chk("trace_valid", trace_valid, m_q.size() > 0);
         if (m_q.size() > 0) begin
            chk("trace_pc", trace_pc, m_q[0].pc);
            chk("trace_ins", trace_ins, m_q[0].ins);
         end
      end
   end

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic wait_run();
      int n = 0;
      while (state !== ST_RUN && n < 20) begin @(negedge clk); n++; end
      chk("wait_run", state, ST_RUN);
   endtask

   task automatic drain(input string nm, input int cnt, input int base, input int step);
      for (int i = 0; i < cnt; i++) begin
         chk(nm, trace_pc, 32'(base + i * step));
         trace_rd = 1'b1;
         @(negedge clk);
      end
      trace_rd = 1'b0;
      chk({nm, "_empty"}, trace_valid, 1'b0);
   endtask

   int          n;
   logic [31:0] rpc;
   int          done_cycles;

   initial begin
      rst = 1'b0; current_pc = '0; instruction = NOP; trace_rd = 1'b0;
      repeat (3) @(negedge clk);

      // Reset hold length and clean RUN entry
      rst = 1'b1;
      n = 0;
      while (core_rst === 1'b1 && n < 20) begin n++; @(negedge clk); end
      chk("t1_core_rst_len", n, 5);
      chk("t1_state", state, 2'b01);
      chk("t1_cycle", cycle_cnt, 0);
      chk("t1_valid", trace_valid, 0);

      // Straight-line code ending in ecall
      for (int i = 0; i < 5; i++) begin
         current_pc  = 32'(i * 4);
         instruction = (i == 4) ? HALT : NOP;
         @(negedge clk);
      end
      instruction = NOP;
      chk("t2_state", state, 2'b10);
      chk("t2_done", done, 1);
      chk("t2_retire", retire_cnt, 5);
      for (int i = 0; i < 3; i++) begin current_pc = 32'h400 + 32'(i * 4); @(negedge clk); end
      chk("t2_frozen_cycle", cycle_cnt, 5);
      chk("t2_frozen_retire", retire_cnt, 5);
      chk("t2_halt_ins_head", trace_ins, NOP);
      drain("t2_trace", 5, 0, 4);

      // Stalled pc
      do_reset(); wait_run();
      current_pc = 32'h100; @(negedge clk);
      current_pc = 32'h20;
      n = 0;
      while (!done && n < 20) begin @(negedge clk); n++; end
      chk("t3_stall_cycles", n, 4);
      chk("t3_state", state, 2'b10);
      chk("t3_retire", retire_cnt, 2);

      // Full FIFO with simultaneous push and pop, then pop on empty
      do_reset(); wait_run();
      for (int i = 0; i < 8; i++) begin current_pc = 32'(i * 4); @(negedge clk); end
      chk("t5_full_retire", retire_cnt, 8);
      current_pc = 32'd32; trace_rd = 1'b1; @(negedge clk);
      trace_rd = 1'b0;
      chk("t5_no_ovf", trace_ovf, 0);
      chk("t5_head", trace_pc, 4);
      n = 0;
      while (!done && n < 10) begin @(negedge clk); n++; end
      chk("t5_halt", state, 2'b10);
      drain("t5_trace", 8, 4, 4);
      trace_rd = 1'b1; repeat (2) @(negedge clk); trace_rd = 1'b0;
      chk("t5_empty_pop", trace_valid, 0);
      chk("t5_empty_ovf", trace_ovf, 0);

      // Timeout with overflow
      do_reset(); wait_run();
      n = 0; rpc = 0;
      while (!done && n < 40) begin current_pc = rpc; rpc += 4; @(negedge clk); n++; end
      chk("t4_cycles", n, 16);
      chk("t4_state", state, 2'b11);
      chk("t4_cycle_cnt", cycle_cnt, 16);
      chk("t4_retire", retire_cnt, 16);
      chk("t4_ovf", trace_ovf, 1);
      drain("t4_trace", 8, 0, 4);

      // Reset mid-run with trace data buffered
      do_reset(); wait_run();
      for (int i = 0; i < 3; i++) begin current_pc = 32'((i + 1) * 8); @(negedge clk); end
      rst = 1'b0; @(negedge clk);
      chk("t6_state", state, 2'b00);
      chk("t6_core_rst", core_rst, 1);
      chk("t6_valid", trace_valid, 0);
      chk("t6_cycle", cycle_cnt, 0);
      chk("t6_retire", retire_cnt, 0);
      rst = 1'b1;

      // Random traffic
      rpc = 0; done_cycles = 0;
      for (int c = 0; c < 700; c++) begin
         int r;
         done_cycles = done ? done_cycles + 1 : 0;
         rst = ($urandom_range(0, 99) < 2 || done_cycles > 6) ? 1'b0 : 1'b1;
         r = $urandom_range(0, 9);
         if (r < 6) rpc += 4;
         else if (r == 9) rpc = $urandom & 32'h0000_00FC;
         current_pc  = rpc;
         instruction = ($urandom_range(0, 39) == 0) ? HALT : $urandom;
         trace_rd    = ($urandom_range(0, 2) == 0);
         @(negedge clk);
      end
      rst = 1'b1; trace_rd = 1'b0;
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
